// File: rtl/sdram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sdram_bist_pkg
// Shared types and helpers for the SDRAM BIST master.
//   bist_state_t : FSM state encoding of the test sequencer.
//   WR_ALL       : byte-enable value for a full 32-bit word write.
//   pattern()    : deterministic test pattern for a word, P(A) = A ^ seed.
// -----------------------------------------------------------------------------
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_ACK,
        S_RD_REQ,
        S_RD_ACK,
        S_FIN
    } bist_state_t;

    localparam logic [3:0] WR_ALL = 4'hF;

    // The address is zero-extended to the data width before mixing with the seed.
    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/sdram_bist_timeout.sv
// -----------------------------------------------------------------------------
// sdram_bist_timeout
// Loadable down-counter that flags when a wait on the core has lasted LIMIT
// cycles. load_i (re)arms it, clear_i disarms it; expired_o is high while armed
// and the count has run out.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : restart the wait window (first cycle after load counts as 1)
//   clear_i      : disarm; takes priority over load_i
//   expired_o    : wait window exhausted
// -----------------------------------------------------------------------------
module sdram_bist_timeout #(
    parameter int LIMIT = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear_i) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (load_i) begin
            // Loading LIMIT-1 makes expired_o rise in the LIMIT-th cycle of the wait.
            cnt_d   = CW'(LIMIT - 1);
            armed_d = 1'b1;
        end else if (armed_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/sdram_bist_master.sv
// -----------------------------------------------------------------------------
// sdram_bist_master
// Power-on self-test initiator for the SDRAM core host port. Writes P(A)=A^seed
// to every word of [base, base+4*num_words) and then reads each word back and
// compares it. One request is outstanding at a time.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : start pulse (ignored while busy)
//   base_addr_i           : window start byte address (bits [1:0] forced to 0)
//   num_words_i, seed_i   : word count and pattern seed, sampled on start
//   core_*_o / core_*_i   : host-port request/accept/ack interface to the core
//   busy_o, done_o        : test running / one-cycle completion pulse
//   pass_o, timeout_o     : sticky result of the last test
//   err_count_o           : saturating count of mismatches and core errors
//   first_err_addr_o/data : address and read data of the first failure
// -----------------------------------------------------------------------------
module sdram_bist_master
    import sdram_bist_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  num_words_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic [ADDR_W-1:0] core_addr_o,
    output logic [DATA_W-1:0] core_write_data_o,
    output logic [3:0]        core_wr_o,
    output logic              core_rd_o,
    input  logic              core_accept_i,
    input  logic              core_ack_i,
    input  logic              core_error_i,
    input  logic [DATA_W-1:0] core_read_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [DATA_W-1:0] first_err_data_o
);

    bist_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [CNT_W-1:0]  nwords_q, nwords_d, rem_q, rem_d, err_q, err_d;
    logic [DATA_W-1:0] seed_q, seed_d, ferr_data_q, ferr_data_d;
    logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
    logic              pass_q, pass_d, tmo_q, tmo_d, done_q, done_d;

    logic              tmo_load, tmo_clear, tmo_expired;
    logic              resp_ev, resp_is_rd, fail, last_word;
    logic [DATA_W-1:0] exp_data;

    assign exp_data  = DATA_W'(pattern(32'(addr_q), 32'(seed_q)));
    assign last_word = (rem_q == CNT_W'(1));

    sdram_bist_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmo_load),
        .clear_i   (tmo_clear),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_d      = base_q;
        nwords_d    = nwords_q;
        rem_d       = rem_q;
        err_d       = err_q;
        seed_d      = seed_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        pass_d      = pass_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;
        tmo_load    = 1'b0;
        tmo_clear   = 1'b0;
        resp_ev     = 1'b0;
        resp_is_rd  = (state_q == S_RD_REQ) || (state_q == S_RD_ACK);
        fail        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d      = base_addr_i & ~ADDR_W'(3);
                    addr_d      = base_addr_i & ~ADDR_W'(3);
                    nwords_d    = num_words_i;
                    rem_d       = num_words_i;
                    seed_d      = seed_i;
                    err_d       = '0;
                    pass_d      = 1'b0;
                    tmo_d       = 1'b0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    if (num_words_i == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_WR_REQ;
                        tmo_load = 1'b1;
                    end
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (core_accept_i) begin
                    // Accept and ack together complete the word without an ACK state.
                    if (core_ack_i) begin
                        resp_ev = 1'b1;
                    end else begin
                        state_d  = resp_is_rd ? S_RD_ACK : S_WR_ACK;
                        tmo_load = 1'b1;
                    end
                end else if (tmo_expired) begin
                    tmo_d     = 1'b1;
                    state_d   = S_FIN;
                    tmo_clear = 1'b1;
                end
            end
            S_WR_ACK, S_RD_ACK: begin
                if (core_ack_i) begin
                    resp_ev = 1'b1;
                end else if (tmo_expired) begin
                    tmo_d     = 1'b1;
                    state_d   = S_FIN;
                    tmo_clear = 1'b1;
                end
            end
            S_FIN: begin
                done_d    = 1'b1;
                pass_d    = (err_q == '0) && !tmo_q;
                state_d   = S_IDLE;
                tmo_clear = 1'b1;
            end
            default: begin
                state_d   = S_IDLE;
                tmo_clear = 1'b1;
            end
        endcase

        if (resp_ev) begin
            // Write acks only fail on core_error; reads also fail on data mismatch.
            fail = core_error_i || (resp_is_rd && (core_read_data_i != exp_data));
            if (fail) begin
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (err_q == '0) begin
                    ferr_addr_d = addr_q;
                    ferr_data_d = resp_is_rd ? core_read_data_i : '0;
                end
            end
            rem_d  = rem_q - CNT_W'(1);
            addr_d = addr_q + ADDR_W'(4);
            if (!last_word) begin
                state_d  = resp_is_rd ? S_RD_REQ : S_WR_REQ;
                tmo_load = 1'b1;
            end else if (!resp_is_rd) begin
                state_d  = S_RD_REQ;
                addr_d   = base_q;
                rem_d    = nwords_q;
                tmo_load = 1'b1;
            end else begin
                state_d   = S_FIN;
                tmo_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            base_q      <= '0;
            nwords_q    <= '0;
            rem_q       <= '0;
            err_q       <= '0;
            seed_q      <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            pass_q      <= 1'b0;
            tmo_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            nwords_q    <= nwords_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            seed_q      <= seed_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
        end
    end

    // Request outputs are decoded from the state register so they drop as soon
    // as the state leaves a REQ state (accept, abort or reset).
    assign core_wr_o         = (state_q == S_WR_REQ) ? WR_ALL : 4'h0;
    assign core_rd_o         = (state_q == S_RD_REQ);
    assign core_addr_o       = ((state_q == S_WR_REQ) || (state_q == S_RD_REQ)) ? addr_q : '0;
    assign core_write_data_o = (state_q == S_WR_REQ) ? exp_data : '0;

    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = tmo_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_addr_q;
    assign first_err_data_o = ferr_data_q;

endmodule

// File: tb/tb_sdram_bist_master.sv
// -----------------------------------------------------------------------------
// tb_sdram_bist_master
// Directed bench for sdram_bist_master. A memory-model responder is advanced
// one cycle at a time by tick(); expected requests are queued when a test is
// started and popped as the DUT's requests are accepted.
// -----------------------------------------------------------------------------
module tb_sdram_bist_master;

    typedef struct {
        logic [31:0] addr;
        logic        is_wr;
        logic [31:0] data;
    } req_t;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [23:0] num_words_i;
    logic [31:0] seed_i;
    logic [31:0] core_addr_o;
    logic [31:0] core_write_data_o;
    logic [3:0]  core_wr_o;
    logic        core_rd_o;
    logic        core_accept_i;
    logic        core_ack_i;
    logic        core_error_i;
    logic [31:0] core_read_data_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        timeout_o;
    logic [23:0] err_count_o;
    logic [31:0] first_err_addr_o;
    logic [31:0] first_err_data_o;

    sdram_bist_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .CNT_W   (24),
        .TIMEOUT (64)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .base_addr_i       (base_addr_i),
        .num_words_i       (num_words_i),
        .seed_i            (seed_i),
        .core_addr_o       (core_addr_o),
        .core_write_data_o (core_write_data_o),
        .core_wr_o         (core_wr_o),
        .core_rd_o         (core_rd_o),
        .core_accept_i     (core_accept_i),
        .core_ack_i        (core_ack_i),
        .core_error_i      (core_error_i),
        .core_read_data_i  (core_read_data_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .timeout_o         (timeout_o),
        .err_count_o       (err_count_o),
        .first_err_addr_o  (first_err_addr_o),
        .first_err_data_o  (first_err_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Responder / scoreboard state
    req_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          stall_mode = 0;
    bit          no_ack     = 0;
    bit          flip_en    = 0;
    logic [31:0] flip_addr  = 32'h0;
    bit          pending    = 0;
    int          pend_cnt   = 0;
    logic [31:0] pend_data  = 32'h0;
    bit          seen       = 0;
    int          stall      = 0;
    logic [31:0] snap_addr, snap_data;
    logic [3:0]  snap_wr;
    logic        snap_rd;
    int          accepts    = 0;
    int          done_cnt   = 0;
    logic [31:0] last_acc_addr = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
        return a ^ s;
    endfunction

    // Advance one cycle: observe DUT at the falling edge, then drive the
    // responder inputs for the next rising edge.
    task automatic tick();
        req_t        e;
        logic [31:0] rd;
        @(negedge clk);
        if (done_o) done_cnt++;
        core_accept_i = 1'b0;
        core_ack_i    = 1'b0;
        core_error_i  = 1'b0;
        if (!busy_o) begin
            pending = 0;
            seen    = 0;
        end else if (pending) begin
            if (pend_cnt > 0) pend_cnt--;
            if (pend_cnt == 0 && !no_ack) begin
                core_ack_i       = 1'b1;
                core_read_data_i = pend_data;
                pending          = 0;
            end
        end else if (core_wr_o != 4'h0 || core_rd_o) begin
            if (!seen) begin
                seen      = 1;
                snap_addr = core_addr_o;
                snap_data = core_write_data_o;
                snap_wr   = core_wr_o;
                snap_rd   = core_rd_o;
                stall     = stall_mode ? int'($urandom_range(0, 10)) : 0;
            end else begin
                chk("stable_addr", core_addr_o, snap_addr);
                chk("stable_wr", core_wr_o, snap_wr);
                chk("stable_rd", core_rd_o, snap_rd);
                chk("stable_data", core_write_data_o, snap_data);
            end
            if (stall > 0) begin
                stall--;
            end else begin
                core_accept_i = 1'b1;
                seen          = 0;
                accepts++;
                last_acc_addr = core_addr_o;
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("req_addr", core_addr_o, e.addr);
                    chk("req_wr", core_wr_o, e.is_wr ? 4'hF : 4'h0);
                    chk("req_rd", core_rd_o, !e.is_wr);
                    if (e.is_wr) chk("req_wdata", core_write_data_o, e.data);
                end
                if (core_wr_o != 4'h0) begin
                    mem[core_addr_o] = core_write_data_o;
                    pend_data        = 32'h0;
                end else begin
                    rd = mem.exists(core_addr_o) ? mem[core_addr_o] : 32'h0;
                    if (flip_en && core_addr_o == flip_addr) rd = rd ^ 32'h1;
                    pend_data = rd;
                end
                pending  = 1;
                pend_cnt = 3;
            end
        end
    endtask

    task automatic push_test(input logic [31:0] base, input int n, input logic [31:0] seed);
        req_t e;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < n; i++) begin
                e.addr  = base + 32'(4 * i);
                e.is_wr = (ph == 0);
                e.data  = pat(e.addr, seed);
                exp_q.push_back(e);
            end
        end
    endtask

    // Pulse start and wait (bounded) for done; returns cycles from the start edge.
    task automatic run_test(input logic [31:0] base, input int n, input logic [31:0] seed,
                            input int bound, output int lat);
        int d0;
        d0          = done_cnt;
        base_addr_i = base;
        num_words_i = 24'(n);
        seed_i      = seed;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        lat     = 1;
        while (done_cnt == d0 && lat < bound) begin
            tick();
            lat++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("idle_at_done", busy_o, 0);
    endtask

    initial begin
        int lat;
        int a0;
        int d0;
        rst_i            = 1'b1;
        start_i          = 1'b0;
        base_addr_i      = 32'h0;
        num_words_i      = 24'h0;
        seed_i           = 32'h0;
        core_accept_i    = 1'b0;
        core_ack_i       = 1'b0;
        core_error_i     = 1'b0;
        core_read_data_i = 32'h0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_errcnt", err_count_o, 0);
        chk("rst_ferr_addr", first_err_addr_o, 0);
        chk("rst_ferr_data", first_err_data_o, 0);
        chk("rst_wr", core_wr_o, 0);
        chk("rst_rd", core_rd_o, 0);
        chk("rst_addr", core_addr_o, 0);
        rst_i = 1'b0;
        tick();

        // Ideal responder, 16 words
        push_test(32'h1000, 16, 32'hA5A5_0000);
        a0 = accepts;
        run_test(32'h1000, 16, 32'hA5A5_0000, 400, lat);
        chk("t1_pass", pass_o, 1);
        chk("t1_errcnt", err_count_o, 0);
        chk("t1_timeout", timeout_o, 0);
        chk("t1_accepts", accepts - a0, 32);
        chk("t1_last_addr", last_acc_addr, 32'h103C);
        chk("t1_sb_empty", exp_q.size(), 0);
        tick();
        chk("t1_done_pulse", done_o, 0);

        // Bit 0 flipped on read at 0x1008
        flip_en   = 1;
        flip_addr = 32'h1008;
        push_test(32'h1000, 16, 32'hA5A5_0000);
        run_test(32'h1000, 16, 32'hA5A5_0000, 400, lat);
        chk("t2_errcnt", err_count_o, 1);
        chk("t2_ferr_addr", first_err_addr_o, 32'h1008);
        chk("t2_ferr_data", first_err_data_o, 32'hA5A5_1009);
        chk("t2_pass", pass_o, 0);
        flip_en = 0;

        // Random accept stalls
        stall_mode = 1;
        push_test(32'h2000, 8, 32'h1234_5678);
        a0 = accepts;
        run_test(32'h2000, 8, 32'h1234_5678, 1000, lat);
        chk("t3_pass", pass_o, 1);
        chk("t3_accepts", accepts - a0, 16);
        chk("t3_sb_empty", exp_q.size(), 0);
        stall_mode = 0;

        // Core never acks
        no_ack = 1;
        push_test(32'h3000, 4, 32'h0);
        a0 = accepts;
        run_test(32'h3000, 4, 32'h0, 300, lat);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_pass", pass_o, 0);
        chk("t4_wr_low", core_wr_o, 0);
        chk("t4_rd_low", core_rd_o, 0);
        chk("t4_accepts", accepts - a0, 1);
        exp_q.delete();
        no_ack = 0;

        // Zero-length test
        a0 = accepts;
        run_test(32'h4000, 0, 32'h0, 20, lat);
        chk("t5_latency", lat, 2);
        chk("t5_accepts", accepts - a0, 0);
        chk("t5_pass", pass_o, 1);
        chk("t5_timeout", timeout_o, 0);

        // Address wrap
        push_test(32'hFFFF_FFF8, 4, 32'hC3C3_3C3C);
        run_test(32'hFFFF_FFF8, 4, 32'hC3C3_3C3C, 200, lat);
        chk("t6_pass", pass_o, 1);
        chk("t6_last_addr", last_acc_addr, 32'h4);
        chk("t6_sb_empty", exp_q.size(), 0);

        // Reset during read phase
        push_test(32'hFFFF_FFF8, 4, 32'hC3C3_3C3C);
        d0          = done_cnt;
        base_addr_i = 32'hFFFF_FFF8;
        num_words_i = 24'd4;
        seed_i      = 32'hC3C3_3C3C;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        lat     = 0;
        while (!core_rd_o && lat < 200) begin
            tick();
            lat++;
        end
        chk("t7_reached_read", core_rd_o, 1);
        rst_i = 1'b1;
        tick();
        chk("t7_busy_drop", busy_o, 0);
        chk("t7_rd_drop", core_rd_o, 0);
        chk("t7_wr_drop", core_wr_o, 0);
        rst_i = 1'b0;
        repeat (20) tick();
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_idle", busy_o, 0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_bist_master.md
Name: sdram_bist_master

Overview:
- Synthesizable initiator for the 32-bit SDRAM core's host port. It drives the same request/accept/ack protocol the core serves.
- Runs a two-phase memory test over a programmed window:
  - Write phase: every word gets a deterministic pattern.
  - Read phase: every word is read back and compared.
- Sits beside the core in FPGA bring-up builds and replaces the host during power-on self test. It reports pass/fail, error count and first failure.

Parameters:
- ADDR_W, 32, host-port byte-address width.
- DATA_W, 32, host-port data width; must be 32.
- CNT_W, 24, width of word-count and error-count registers.
- TIMEOUT, 4096, max cycles waiting for accept or ack before aborting.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; starts a test when idle, ignored while busy.
- base_addr_i  in  ADDR_W  first byte address; bits [1:0] ignored (treated as 0). Sampled on start.
- num_words_i  in  CNT_W  number of 32-bit words to test. Sampled on start.
- seed_i  in  DATA_W  pattern seed. Sampled on start.
- core_addr_o  out  ADDR_W  request byte address.
- core_write_data_o  out  DATA_W  write data.
- core_wr_o  out  4  byte write enables; 4'hF for a write, 0 otherwise.
- core_rd_o  out  1  read request.
- core_accept_i  in  1  core accepted the current request this cycle.
- core_ack_i  in  1  request completed; read data valid this cycle.
- core_error_i  in  1  core error flag, qualified by ack.
- core_read_data_i  in  DATA_W  read data.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at completion.
- pass_o  out  1  sticky result of last test: 1 if zero errors and no timeout.
- timeout_o  out  1  sticky; last test aborted on timeout.
- err_count_o  out  CNT_W  mismatches plus core_error acks; saturating.
- first_err_addr_o  out  ADDR_W  address of first failure.
- first_err_data_o  out  DATA_W  data read at first failure.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0.
- Pattern for word at byte address A: P(A) = A ^ seed. The address term is zero-extended to DATA_W.
- FSM states and transitions:
  - IDLE: on start_i, latch inputs, clear err_count/pass/timeout/first_err. If num_words = 0, go to FIN. Otherwise go to WR_REQ with addr = base.
  - WR_REQ: drive core_wr_o = 4'hF, core_addr_o = addr, core_write_data_o = P(addr). Hold all stable until the cycle core_accept_i = 1, then go to WR_ACK and deassert wr the next cycle.
  - WR_ACK: wait for core_ack_i. core_error_i on that ack counts as an error and records the address, with first_err_data = 0.
    - If words remain: addr += 4, go to WR_REQ.
    - Otherwise: addr = base, go to RD_REQ.
  - RD_REQ: core_rd_o = 1 with core_addr_o = addr, held until accept, then go to RD_ACK.
  - RD_ACK: on core_ack_i, compare core_read_data_i against P(addr). A mismatch or core_error_i increments err_count and captures first_err if it is the first failure.
    - If words remain: addr += 4, go to RD_REQ.
    - Otherwise: go to FIN.
  - FIN: pulse done_o, set pass_o = (err_count == 0 && !timeout_o), go to IDLE.
- At most one outstanding request. The next request is issued no earlier than the cycle after ack.
- Address wraps modulo 2^ADDR_W with no error.
- err_count saturates at all-ones.
- Timeout counter resets on entry to each REQ/ACK state. On reaching TIMEOUT:
  - set timeout_o, drop wr/rd, go to FIN;
  - pass_o = 0.
- accept and ack in the same cycle from a REQ state: treat as accept, then ack. Go straight to the next word without entering the ACK state.
- ack while not in an ACK state is ignored.
- start_i while busy is ignored.
- busy_o = 1 in every state except IDLE.
- Reset asserted mid-test returns to IDLE within one cycle. Requests drop immediately; no done_o pulse.

Decomposition:
- Package sdram_bist_pkg: state enum, function pattern(addr, seed), localparam WR_ALL = 4'hF.
- One sub-module is natural: sdram_bist_timeout. It is a loadable down-counter with a clear input and an expired output.

Test Plan:
- Ideal responder (accept same cycle, ack +3, memory model), base 0x1000, 16 words, seed 0xA5A5_0000:
  - 16 writes then 16 reads, last address 0x103C;
  - done pulse, pass = 1, err_count = 0.
- Same responder, but the model flips bit 0 at 0x1008 on read: err_count = 1, first_err_addr = 0x1008, first_err_data = 0xA5A5_1009, pass = 0.
- Responder with random 0–10 cycle accept stall: addr/wr/data stable while accept is low; each request is issued exactly once.
- Responder never acks, TIMEOUT = 64: abort with timeout_o = 1, pass = 0, wr/rd low after abort.
- num_words = 0: done pulse 2 cycles after start, no requests, pass = 1.
- Base 0xFFFF_FFF8, 4 words: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; pass = 1. Reset mid-read-phase: busy drops next cycle, no done pulse.
